// File: rtl/sdram_pixel_burst_writer.sv
// Pixel FIFO and fixed-length write-burst packer feeding the DDR SDRAM controller local interface.
// Optional drop counter enabled by defining SDRAM_WR_DROP_COUNT_EN.
module sdram_pixel_burst_writer #(
  parameter int unsigned BURST_LEN   = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter logic [22:0] BASE_ADDR   = 23'd0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [15:0]                     pix_data,
  input  logic                            pix_valid,
  input  logic                            pix_sof,
  input  logic                            local_init_done,
  input  logic                            local_ready,
  output logic                            local_write_req,
  output logic                            local_burstbegin,
  output logic [2:0]                      local_size,
  output logic [22:0]                     local_address,
  output logic [1:0]                      local_be,
  output logic [15:0]                     local_wdata,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            sof_misalign,
  output logic [15:0]                     drop_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state, state_nxt;
  logic [16:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   count;
  logic [16:0]     head;
  logic            full, push, pop, accept, last_beat, start;
  logic [22:0]     offset, offset_eff, offset_inc;
  logic [BW-1:0]   beat_cnt;
  logic            first_pending;

  assign head       = mem[rd_ptr];
  assign full       = (count == LW'(FIFO_DEPTH));
  assign push       = pix_valid && !full;
  assign accept     = (state == BURST) && local_ready;
  assign pop        = accept;
  assign last_beat  = accept && (beat_cnt == BW'(BURST_LEN - 1));
  assign start      = (state == IDLE) && local_init_done && (count >= LW'(BURST_LEN));
  // A SOF tag at the burst head restarts the frame at offset 0.
  assign offset_eff = head[16] ? '0 : offset;
  assign offset_inc = offset + 23'(BURST_LEN);
  assign fifo_level = count;
  assign local_size = 3'(BURST_LEN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    local_be         = 2'b00;
    local_wdata      = '0;
    case (state)
      IDLE: if (start) state_nxt = BURST;
      BURST: begin
        local_write_req  = 1'b1;
        local_burstbegin = first_pending;
        local_be         = 2'b11;
        local_wdata      = head[15:0];
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pix_sof, pix_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      offset        <= '0;
      local_address <= BASE_ADDR;
      beat_cnt      <= '0;
      first_pending <= 1'b0;
      overflow      <= 1'b0;
      sof_misalign  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + LW'(push) - LW'(pop);
      if (pix_valid && full) overflow <= 1'b1;
      if (start) begin
        offset        <= offset_eff;
        local_address <= BASE_ADDR + offset_eff;
        beat_cnt      <= '0;
        first_pending <= 1'b1;
      end
      if (accept) begin
        first_pending <= 1'b0;
        beat_cnt      <= beat_cnt + 1'b1;
        if (head[16] && (beat_cnt != '0)) sof_misalign <= 1'b1;
        if (last_beat) begin
          beat_cnt <= '0;
          offset   <= (offset_inc == 23'(FRAME_WORDS)) ? '0 : offset_inc;
        end
      end
    end
  end

`ifdef SDRAM_WR_DROP_COUNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                         drop_cnt_q <= '0;
    else if (pix_valid && full && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule
